fwd_scoreboard: RTL
===================

# fwd_scoreboard

Parametrised bypass and hazard block for the pipelined CPU. It tracks the destination register and result-ready countdown of every in-flight instruction in a shift pipeline of `NSTG` stages. For each of `NRP` operand read ports it selects the forwarded value and raises a stall when a producer cannot deliver in time. It replaces the fixed per-operand forwarding muxes: a single scoreboard-driven network serves any number of operand consumers (ALU A/B, comparator A/B, jump register, store data).

## Interface
Parameters:
- `DW`, 32, data width
- `AW`, 5, register address width
- `NRP`, 3, number of operand read ports
- `NSTG`, 3, tracked stages after issue (stage 0 = EX, stage `NSTG`-1 = WB)
- `TW`, 2, width of tnew/tuse counters

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-low reset
- `flush`  in  1  synchronous clear of all tracked entries
- `iss_valid`  in  1  instruction in decode wants to issue this cycle
- `iss_we`  in  1  issuing instruction writes a register
- `iss_waddr`  in  AW  its destination register
- `iss_tnew`  in  TW  cycles after entering stage 0 until its result is on `stg_data`
- `rd_addr`  in  NRP*AW  source register per port, port p at [p*AW +: AW]
- `rd_tuse`  in  NRP*TW  cycles until port p's consumer needs the value
- `rf_data`  in  NRP*DW  register-file read data per port
- `stg_data`  in  NSTG*DW  result bus of each tracked stage
- `fwd_data`  out  NRP*DW  operand per port
- `fwd_hit`  out  NRP  port p is taking data from `stg_data`
- `stall`  out  1  hold decode/fetch; a bubble enters stage 0
- `stall_cnt`  out  32  saturating count of stall cycles

## Operation
- Entry k (0..NSTG-1) holds {v, addr, tnew}. An entry is valid only if the instruction was issued with `iss_we`=1 and `iss_waddr`≠0.
- Shift on every edge, unless reset or flush applies:
  - entry[0] ← issuing instruction if `iss_valid` && !`stall`, else bubble (v=0)
  - entry[k] ← entry[k-1], with tnew decremented and saturating at 0
  - entry[NSTG-1] is discarded. The register file is write-through, so it supplies that value.
- Match for port p, where `rd_addr`≠0: the lowest-index (youngest) valid entry with addr == `rd_addr`. Older matches are ignored.
  - Match with tnew==0: `fwd_data`=`stg_data`[k], `fwd_hit`=1
  - Match with 0 < tnew ≤ tuse: `fwd_data`=`rf_data`, `fwd_hit`=0, no stall. A later stage's forwarding resolves it.
  - Match with tnew > tuse: port requests stall
  - No match, or `rd_addr`==0: `fwd_data`=`rf_data`, `fwd_hit`=0
- `stall` = OR of per-port requests, gated by `iss_valid`.
- `stall_cnt` increments on each edge where `stall`=1. It saturates at 0xFFFFFFFF and is cleared only by reset, not by flush.

## Timing
- Reset (`reset`=0 at edge): all v=0, `stall_cnt`=0. While entries are empty: `stall`=0, `fwd_hit`=0, `fwd_data`=`rf_data`.
- Reset beats flush, and flush beats issue. Any instruction issuing in a flush cycle is dropped, and all entries are v=0 after the edge.
- `stall`, `fwd_data` and `fwd_hit` are combinational from the registered entries and the current-cycle inputs. Zero latency; same-cycle use is required.
- Entry state is registered, so an issued instruction is visible at stage 0 one edge later.
- When two ports read the same register, each resolves independently to the same entry.

## Test plan
- Back-to-back dependency: issue r8 with tnew=0. Next cycle, port 0 reads r8 with tuse=0 and `stg_data`[0]=0x1234 → `fwd_data`[0]=0x1234, `fwd_hit`[0]=1, `stall`=0.
- Load-use: issue r9 with tnew=1. Next cycle, port 1 reads r9 with tuse=0:
  - expect `stall`=1 for exactly one cycle and a bubble in stage 0
  - then with `stg_data`[1]=0xCAFE → `fwd_data`[1]=0xCAFE
  - `stall_cnt`=1
- Youngest wins: issue r3 (tnew=0), then r3 again (tnew=0). With `stg_data`[0]=0xA and `stg_data`[1]=0xB, a read of r3 → 0xA.
- Register zero: issue a write to r0, then read r0 with `rf_data`=0 → `fwd_hit`=0, `fwd_data`=0, no stall.
- Retire: issue r5, then NSTG bubbles. A read of r5 → `rf_data` passes through and `fwd_hit`=0.
- Flush and reset mid-operation:
  - a pending stall (tnew=2) plus `flush` → next cycle `stall`=0, while `stall_cnt` keeps its value
  - `reset`=0 → `stall_cnt`=0

Source files
------------

// File: rtl/fwd_scoreboard.sv
// Scoreboard-driven bypass network: tracks in-flight destination registers and
// result-ready countdowns, selects forwarded operands and raises decode stalls.
module fwd_scoreboard #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int NRP  = 3,
    parameter int NSTG = 3,
    parameter int TW   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                iss_valid,
    input  logic                iss_we,
    input  logic [AW-1:0]       iss_waddr,
    input  logic [TW-1:0]       iss_tnew,
    input  logic [NRP*AW-1:0]   rd_addr,
    input  logic [NRP*TW-1:0]   rd_tuse,
    input  logic [NRP*DW-1:0]   rf_data,
    input  logic [NSTG*DW-1:0]  stg_data,
    output logic [NRP*DW-1:0]   fwd_data,
    output logic [NRP-1:0]      fwd_hit,
    output logic                stall,
    output logic [31:0]         stall_cnt
);

    logic          ent_v    [NSTG];
    logic [AW-1:0] ent_addr [NSTG];
    logic [TW-1:0] ent_tnew [NSTG];

    logic [NRP-1:0] m_found;
    logic [TW-1:0]  m_tnew [NRP];
    logic [DW-1:0]  m_data [NRP];
    logic [NRP-1:0] port_req;
    logic           issue_v;

    // Youngest match wins: scan from stage 0 and latch the first hit only.
    always_comb begin
        m_found = '0;
        for (int unsigned p = 0; p < NRP; p++) begin
            m_tnew[p] = '0;
            m_data[p] = '0;
            for (int unsigned k = 0; k < NSTG; k++) begin
                if (!m_found[p] && ent_v[k] && (rd_addr[p*AW +: AW] != '0) &&
                    (ent_addr[k] == rd_addr[p*AW +: AW])) begin
                    m_found[p] = 1'b1;
                    m_tnew[p]  = ent_tnew[k];
                    m_data[p]  = stg_data[k*DW +: DW];
                end
            end
        end
    end

    always_comb begin
        fwd_data = rf_data;
        fwd_hit  = '0;
        port_req = '0;
        for (int unsigned p = 0; p < NRP; p++) begin
            if (m_found[p] && (m_tnew[p] == '0)) begin
                fwd_data[p*DW +: DW] = m_data[p];
                fwd_hit[p]           = 1'b1;
            end
            port_req[p] = m_found[p] && (m_tnew[p] > rd_tuse[p*TW +: TW]);
        end
    end

    assign stall   = iss_valid && (|port_req);
    assign issue_v = iss_valid && !stall && iss_we && (iss_waddr != '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt <= '0;
            for (int unsigned k = 0; k < NSTG; k++) begin
                ent_v[k]    <= 1'b0;
                ent_addr[k] <= '0;
                ent_tnew[k] <= '0;
            end
        end else begin
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 32'd1;
            if (flush) begin
                for (int unsigned k = 0; k < NSTG; k++)
                    ent_v[k] <= 1'b0;
            end else begin
                ent_v[0]    <= issue_v;
                ent_addr[0] <= iss_waddr;
                ent_tnew[0] <= iss_tnew;
                for (int unsigned k = 1; k < NSTG; k++) begin
                    ent_v[k]    <= ent_v[k-1];
                    ent_addr[k] <= ent_addr[k-1];
                    ent_tnew[k] <= (ent_tnew[k-1] == '0) ? '0 : ent_tnew[k-1] - TW'(1);
                end
            end
        end
    end

endmodule
